// File: rtl/loop_ctl_pkg.sv
// Shared loop-nest constants for the conv layer controllers, plus a width helper
// usable in parameter and localparam expressions.
package loop_ctl_pkg;

  localparam int X_MAX       = 29;
  localparam int Y_MAX       = 29;
  localparam int K_MAX       = 16;
  localparam int J_MAX       = 16;
  localparam int PERIOD_DEF  = 8;
  localparam int TAP_MID_DEF = 4;

  // Bits needed to hold the values 0..v-1. Never returns less than 1.
  function automatic int clog2w(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/loop_phase_seq_pend_cnt.sv
// Saturating counter of queued start requests. A request that arrives while the
// counter is full is dropped, and that drop is remembered in a sticky flag.
module pend_cnt
  import loop_ctl_pkg::*;
#(
  parameter int  DEPTH = 3,
  localparam int QW    = clog2w(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic empty,
  output logic ovf_sticky
);

  logic [QW-1:0] count;
  logic          full;

  assign full  = (count == QW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      ovf_sticky <= 1'b0;
    end else if (clr) begin
      count      <= '0;
      ovf_sticky <= 1'b0;
    end else if (inc && !dec) begin
      if (full) ovf_sticky <= 1'b1;
      else      count      <= count + QW'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - QW'(1);
    end
  end

endmodule

// File: rtl/loop_phase_seq.sv
// Phase sequencer for one conv layer. Each trigger runs one phase sequence
// 1..PERIOD. Triggers that arrive while a sequence is running are queued.
module loop_phase_seq
  import loop_ctl_pkg::*;
#(
  parameter int  PERIOD     = PERIOD_DEF,
  parameter int  TAP_MID    = TAP_MID_DEF,
  parameter int  INIT_PHASE = 5,
  parameter int  PEND_DEPTH = 3,
  parameter int  LOOPS      = 841,
  localparam int PW         = clog2w(PERIOD + 1),
  localparam int SW         = clog2w(LOOPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  input  logic          stall,
  input  logic          clr,
  output logic          count_en,
  output logic [PW-1:0] phase,
  output logic          tap_mid,
  output logic          tap_end,
  output logic [SW-1:0] seq_cnt,
  output logic          done,
  output logic          pend_ovf
);

  if (TAP_MID > PERIOD || TAP_MID == 0 || INIT_PHASE > PERIOD ||
      PEND_DEPTH < 1 || LOOPS < 2) begin : g_bad_params
    $error("loop_phase_seq: illegal parameter combination");
  end

  localparam logic [PW-1:0] PH_END   = PW'(PERIOD);
  localparam logic [PW-1:0] PH_MID   = PW'(TAP_MID);
  localparam logic [PW-1:0] PH_INIT  = PW'(INIT_PHASE);
  localparam logic [SW-1:0] SEQ_LAST = SW'(LOOPS - 1);

  logic pend_empty;
  logic idle;
  logic at_end;
  logic avail;
  logic run;
  logic pend_inc;
  logic pend_dec;

  assign idle   = (phase == '0);
  assign at_end = (phase == PH_END);
  assign avail  = trig | !pend_empty;
  assign run    = !clr & !stall;

  // A trigger is queued only when it cannot start a sequence this cycle.
  // The queue is drained only at a start point, and only when no live trigger is present.
  assign pend_inc = trig & !clr & (stall | (!idle & !at_end));
  assign pend_dec = run & !trig & !pend_empty & (idle | at_end);

  assign count_en = !stall & (!idle | avail);
  assign tap_mid  = (phase == PH_MID);
  assign tap_end  = at_end;

  pend_cnt #(
    .DEPTH (PEND_DEPTH)
  ) u_pend (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .inc        (pend_inc),
    .dec        (pend_dec),
    .empty      (pend_empty),
    .ovf_sticky (pend_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= PH_INIT;
      seq_cnt <= '0;
      done    <= 1'b0;
    end else if (clr) begin
      phase   <= '0;
      seq_cnt <= '0;
      done    <= 1'b0;
    end else if (stall) begin
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (idle) begin
        if (avail) phase <= PW'(1);
      end else if (at_end) begin
        // The next sequence starts back-to-back if work is pending, with no idle cycle in between.
        phase   <= avail ? PW'(1) : '0;
        seq_cnt <= (seq_cnt == SEQ_LAST) ? '0 : seq_cnt + SW'(1);
        done    <= (seq_cnt == SEQ_LAST);
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_loop_phase_seq.sv
// Directed bench for loop_phase_seq: default instance plus a LOOPS=4 instance for done/wrap.
module tb_loop_phase_seq;

  logic       clk = 1'b0;
  logic       rst, trig, stall, clr;
  logic       count_en, tap_mid, tap_end, done, pend_ovf;
  logic [3:0] phase;
  logic [9:0] seq_cnt;

  logic       trig4, stall4, clr4;
  logic       count_en4, tap_mid4, tap_end4, done4, pend_ovf4;
  logic [3:0] phase4;
  logic [1:0] seq4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  loop_phase_seq dut (
    .clk      (clk),
    .rst      (rst),
    .trig     (trig),
    .stall    (stall),
    .clr      (clr),
    .count_en (count_en),
    .phase    (phase),
    .tap_mid  (tap_mid),
    .tap_end  (tap_end),
    .seq_cnt  (seq_cnt),
    .done     (done),
    .pend_ovf (pend_ovf)
  );

  loop_phase_seq #(.LOOPS(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .trig     (trig4),
    .stall    (stall4),
    .clr      (clr4),
    .count_en (count_en4),
    .phase    (phase4),
    .tap_mid  (tap_mid4),
    .tap_end  (tap_end4),
    .seq_cnt  (seq4),
    .done     (done4),
    .pend_ovf (pend_ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs to the default instance, check count_en before the edge,
  // then check the phase, queue depth, taps and done after the edge.
  task automatic cyc(input logic t, input logic s, input logic c,
                     input int ph_exp, input int pend_exp, input int cen_exp);
    trig = t; stall = s; clr = c;
    #1;
    chk("count_en", count_en, cen_exp);
    @(posedge clk); #1;
    trig = 1'b0; stall = 1'b0; clr = 1'b0;
    chk("phase", phase, ph_exp);
    chk("pend", dut.u_pend.count, pend_exp);
    chk("tap_mid", tap_mid, (ph_exp == 4) ? 1 : 0);
    chk("tap_end", tap_end, (ph_exp == 8) ? 1 : 0);
    chk("done", done, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; trig = 1'b0; stall = 1'b0; clr = 1'b0;
    trig4 = 1'b0; stall4 = 1'b0; clr4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", phase, 5);
    chk("rst_pend", dut.u_pend.count, 0);
    chk("rst_seq", seq_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", pend_ovf, 0);
    rst = 1'b1;

    // Partial first sequence from INIT_PHASE, then idle.
    cyc(0, 0, 0, 6, 0, 1);
    cyc(0, 0, 0, 7, 0, 1);
    cyc(0, 0, 0, 8, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("seq_after_init", seq_cnt, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // A single trigger from idle.
    cyc(1, 0, 0, 1, 0, 1);
    for (int p = 2; p <= 8; p++) cyc(0, 0, 0, p, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("seq_single", seq_cnt, 2);
    cyc(0, 0, 0, 0, 0, 0);

    // Triggers at phase 3 and at phase 8: back-to-back sequences, queue drains.
    cyc(1, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 2, 0, 1);
    cyc(0, 0, 0, 3, 0, 1);
    cyc(1, 0, 0, 4, 1, 1);
    for (int p = 5; p <= 8; p++) cyc(0, 0, 0, p, 1, 1);
    cyc(1, 0, 0, 1, 1, 1);
    for (int p = 2; p <= 8; p++) cyc(0, 0, 0, p, 1, 1);
    cyc(0, 0, 0, 1, 0, 1);
    for (int p = 2; p <= 8; p++) cyc(0, 0, 0, p, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("seq_b2b", seq_cnt, 5);

    // Queue overflow: the fourth queued trigger is dropped and the flag sticks.
    cyc(1, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 2, 1, 1);
    cyc(1, 0, 0, 3, 2, 1);
    cyc(1, 0, 0, 4, 3, 1);
    chk("ovf_before", pend_ovf, 0);
    cyc(1, 0, 0, 5, 3, 1);
    chk("ovf_set", pend_ovf, 1);
    for (int p = 6; p <= 8; p++) cyc(0, 0, 0, p, 3, 1);
    cyc(0, 0, 0, 1, 2, 1);
    chk("ovf_sticky", pend_ovf, 1);
    chk("seq_pre_clr", seq_cnt, 6);
    cyc(0, 0, 1, 0, 0, 1);
    chk("ovf_clr", pend_ovf, 0);
    chk("seq_clr", seq_cnt, 0);

    // Stall at phase 6 with a trigger: phase holds, trigger queued.
    cyc(1, 0, 0, 1, 0, 1);
    for (int p = 2; p <= 6; p++) cyc(0, 0, 0, p, 0, 1);
    cyc(1, 1, 0, 6, 1, 0);
    cyc(0, 1, 0, 6, 1, 0);
    cyc(0, 1, 0, 6, 1, 0);
    cyc(0, 0, 0, 7, 1, 1);
    cyc(0, 0, 0, 8, 1, 1);
    cyc(0, 0, 0, 1, 0, 1);
    for (int p = 2; p <= 8; p++) cyc(0, 0, 0, p, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("seq_stall", seq_cnt, 2);

    // Asynchronous reset mid-sequence with work queued.
    cyc(1, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 2, 1, 1);
    rst = 1'b0;
    #2;
    chk("mid_rst_phase", phase, 5);
    chk("mid_rst_pend", dut.u_pend.count, 0);
    chk("mid_rst_seq", seq_cnt, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 6, 0, 1);

    // LOOPS=4 instance: done pulses one cycle after the fourth completion.
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    chk("l4_clr_phase", phase4, 0);
    chk("l4_clr_seq", seq4, 0);
    chk("l4_cen_idle", count_en4, 0);
    for (int s = 1; s <= 4; s++) begin
      trig4 = 1'b1;
      tick();
      trig4 = 1'b0;
      chk("l4_phase1", phase4, 1);
      repeat (3) tick();
      chk("l4_tap_mid", tap_mid4, 1);
      repeat (4) tick();
      chk("l4_tap_end", tap_end4, 1);
      chk("l4_done_pre", done4, 0);
      tick();
      chk("l4_phase0", phase4, 0);
      chk("l4_seq", seq4, s % 4);
      chk("l4_done", done4, (s == 4) ? 1 : 0);
    end
    tick();
    chk("l4_done_pulse_end", done4, 0);
    trig4 = 1'b1;
    tick();
    trig4 = 1'b0;
    repeat (2) tick();
    chk("l4_mid_phase", phase4, 3);
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    chk("l4_clr_mid_phase", phase4, 0);
    chk("l4_clr_mid_seq", seq4, 0);
    chk("l4_ovf", pend_ovf4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
